csr_timer_controller: RTL

//  Sequences the 64-bit CSR timer: a prescaler generates its count strobe, and a 64-bit compare drives the timer interrupt.

---
 rtl/csr_timer_controller_pkg.sv | 35 +++
 rtl/csr_timer_prescaler.sv | 35 +++
 rtl/csr_timer_controller.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/csr_timer_controller_pkg.sv
// Shared definitions for the CSR timer controller: FSM state encoding,
// control CSR bit layout, default CSR addresses and the control write mask.
package csr_timer_controller_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_FIRED    = 2'd2
    } timer_state_t;

    localparam int CTRL_ENABLE      = 0;
    localparam int CTRL_IRQ_ENABLE  = 1;
    localparam int CTRL_PERIODIC    = 2;
    localparam int CTRL_DIVISOR_LSB = 16;
    localparam int CTRL_DIVISOR_W   = 16;

    localparam logic [11:0] DEFAULT_ADDRESS_CONTROL       = 12'h7C0;
    localparam logic [11:0] DEFAULT_ADDRESS_COMPARE_LOWER = 12'h7C1;
    localparam logic [11:0] DEFAULT_ADDRESS_COMPARE_UPPER = 12'h7C2;
    localparam logic [11:0] DEFAULT_ADDRESS_STATUS        = 12'h7C3;
    localparam logic [11:0] DEFAULT_ADDRESS_PERIOD        = 12'h7C4;

    // Writable bits of the control CSR; the periodic bit exists only when
    // auto-reload is built in, everything else reads back as zero.
    function automatic logic [31:0] control_write_mask(input logic periodic_supported);
        logic [31:0] mask;
        mask = '0;
        mask[CTRL_DIVISOR_LSB +: CTRL_DIVISOR_W] = '1;
        mask[CTRL_ENABLE]     = 1'b1;
        mask[CTRL_IRQ_ENABLE] = 1'b1;
        mask[CTRL_PERIODIC]   = periodic_supported;
        return mask;
    endfunction

endpackage

// File: rtl/csr_timer_prescaler.sv
// Prescaler for the CSR timer: emits a one-cycle count strobe every
// (divisor+1) enabled cycles. Disabling or a divisor rewrite restarts it.
module csr_timer_prescaler
    import csr_timer_controller_pkg::*;
#(
    parameter int DIVISOR_W = CTRL_DIVISOR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 restart,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic                 count
);

    logic [DIVISOR_W-1:0] counter;

    // Count enabled cycles; strobe and wrap when the divisor is reached.
    always_ff @(posedge clk) begin
        if (!rst) begin
            counter <= '0;
            count   <= 1'b0;
        end else if (!enable || restart) begin
            counter <= '0;
            count   <= 1'b0;
        end else if (counter == divisor) begin
            counter <= '0;
            count   <= 1'b1;
        end else begin
            counter <= counter + 1'b1;
            count   <= 1'b0;
        end
    end

endmodule

// File: rtl/csr_timer_controller.sv
// CSR timer controller: control/compare/status CSRs, 64-bit compare against
// the timer value and the interrupt FSM. The optional periodic auto-reload
// (period CSR, control bit 2) is built only when TIMER_AUTO_RELOAD_EN is
// defined.
module csr_timer_controller
    import csr_timer_controller_pkg::*;
#(
    parameter logic [11:0] ADDRESS_CONTROL       = DEFAULT_ADDRESS_CONTROL,
    parameter logic [11:0] ADDRESS_COMPARE_LOWER = DEFAULT_ADDRESS_COMPARE_LOWER,
    parameter logic [11:0] ADDRESS_COMPARE_UPPER = DEFAULT_ADDRESS_COMPARE_UPPER,
    parameter logic [11:0] ADDRESS_STATUS        = DEFAULT_ADDRESS_STATUS
`ifdef TIMER_AUTO_RELOAD_EN
    ,
    parameter logic [11:0] ADDRESS_PERIOD        = DEFAULT_ADDRESS_PERIOD
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csrReadEnable,
    input  logic [11:0] csrReadAddress,
    output logic [31:0] csrReadData,
    output logic        csrRequestOutput,
    input  logic        csrWriteEnable,
    input  logic [11:0] csrWriteAddress,
    input  logic [31:0] csrWriteData,
    input  logic [63:0] timerValue,
    output logic        timerCount,
    output logic        timerInterrupt
);

`ifdef TIMER_AUTO_RELOAD_EN
    localparam logic [31:0] CONTROL_MASK = control_write_mask(1'b1);
`else
    localparam logic [31:0] CONTROL_MASK = control_write_mask(1'b0);
`endif

    logic [31:0]  control;
    logic [31:0]  control_next;
    logic [31:0]  shadow;
    logic [63:0]  compare;
    timer_state_t state;

    logic write_control;
    logic write_lower;
    logic write_upper;
    logic write_status;
    logic enabled_next;
    logic compare_true;
    logic fire;
    logic clear;
    logic read_hit;
    logic [31:0] read_value;

    assign write_control = csrWriteEnable && (csrWriteAddress == ADDRESS_CONTROL);
    assign write_lower   = csrWriteEnable && (csrWriteAddress == ADDRESS_COMPARE_LOWER);
    assign write_upper   = csrWriteEnable && (csrWriteAddress == ADDRESS_COMPARE_UPPER);
    assign write_status  = csrWriteEnable && (csrWriteAddress == ADDRESS_STATUS);

    // The FSM looks at the control value being written this cycle so that
    // dropping enable/irqEnable deasserts the interrupt on the next cycle.
    assign control_next = write_control ? (csrWriteData & CONTROL_MASK) : control;
    assign enabled_next = control_next[CTRL_ENABLE] && control_next[CTRL_IRQ_ENABLE];
    assign compare_true = (timerValue >= compare);
    // An upper commit in the same cycle supersedes the stale compare value.
    assign fire         = (state == ST_ARMED) && enabled_next && compare_true && !write_upper;
    assign clear        = write_upper || (write_status && csrWriteData[0]);

`ifdef TIMER_AUTO_RELOAD_EN
    logic [31:0] period;
    logic        write_period;
    logic        reload;

    assign write_period = csrWriteEnable && (csrWriteAddress == ADDRESS_PERIOD);
    assign reload       = fire && control_next[CTRL_PERIODIC];

    // Period CSR holding the auto-reload increment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            period <= '0;
        end else if (write_period) begin
            period <= csrWriteData;
        end
    end
`endif

    // Control CSR and the lower-half shadow awaiting an upper commit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            control <= '0;
            shadow  <= '0;
        end else begin
            control <= control_next;
            if (write_lower) begin
                shadow <= csrWriteData;
            end
        end
    end

    // Compare register: atomic 64-bit commit on upper write, optional reload.
    always_ff @(posedge clk) begin
        if (!rst) begin
            compare <= '1;
        end else if (write_upper) begin
            compare <= {csrWriteData, shadow};
`ifdef TIMER_AUTO_RELOAD_EN
        end else if (reload) begin
            compare <= compare + {32'b0, period};
`endif
        end
    end

    // Interrupt FSM with a registered level interrupt output.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_DISABLED;
            timerInterrupt <= 1'b0;
        end else if (!enabled_next) begin
            state          <= ST_DISABLED;
            timerInterrupt <= 1'b0;
        end else begin
            case (state)
                ST_DISABLED: begin
                    state          <= ST_ARMED;
                    timerInterrupt <= 1'b0;
                end
                ST_ARMED: begin
                    if (fire) begin
                        state <= ST_FIRED;
                    end
                    timerInterrupt <= fire;
                end
                ST_FIRED: begin
                    if (clear) begin
                        state          <= ST_ARMED;
                        timerInterrupt <= 1'b0;
                    end else begin
                        timerInterrupt <= 1'b1;
                    end
                end
                default: begin
                    state          <= ST_DISABLED;
                    timerInterrupt <= 1'b0;
                end
            endcase
        end
    end

    csr_timer_prescaler #(
        .DIVISOR_W(CTRL_DIVISOR_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (control[CTRL_ENABLE]),
        .restart(write_control),
        .divisor(control[CTRL_DIVISOR_LSB +: CTRL_DIVISOR_W]),
        .count  (timerCount)
    );

    // CSR read decode; returns registered (pre-write) values.
    always_comb begin
        read_hit   = 1'b0;
        read_value = '0;
        if (csrReadAddress == ADDRESS_CONTROL) begin
            read_hit   = 1'b1;
            read_value = control;
        end else if (csrReadAddress == ADDRESS_COMPARE_LOWER) begin
            read_hit   = 1'b1;
            read_value = compare[31:0];
        end else if (csrReadAddress == ADDRESS_COMPARE_UPPER) begin
            read_hit   = 1'b1;
            read_value = compare[63:32];
        end else if (csrReadAddress == ADDRESS_STATUS) begin
            read_hit   = 1'b1;
            read_value = {30'b0, (state == ST_ARMED), (state == ST_FIRED)};
`ifdef TIMER_AUTO_RELOAD_EN
        end else if (csrReadAddress == ADDRESS_PERIOD) begin
            read_hit   = 1'b1;
            read_value = period;
`endif
        end
    end

    assign csrRequestOutput = csrReadEnable && read_hit;
    assign csrReadData      = csrRequestOutput ? read_value : 32'b0;

endmodule
